centroid_marker_overlay: RTL and testbench

//  Downstream of the centroid stage: draws a cross-hair marker at the last computed

---
 rtl/centroid_marker_overlay.sv | 160 ++++++++++++++++
 tb/tb_centroid_marker_overlay.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/centroid_marker_overlay.sv
// centroid_marker_overlay
// Draws a cross-hair at the centroid latched at the start of each frame onto a
// pass-through RGB video stream. The stream has a fixed two-cycle latency:
// stage 1 registers the video and the hit decision, and stage 2 substitutes
// the marker colour.
module centroid_marker_overlay #(
   parameter logic [10:0] IMG_H     = 11'd64,
   parameter logic [10:0] IMG_W     = 11'd64,
   parameter logic [7:0]  MARK_HALF = 8'd8,
   parameter logic [23:0] MARK_RGB  = 24'hFF0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        de_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic [23:0] pixel_in,
   input  logic [10:0] x_c,
   input  logic [10:0] y_c,
   input  logic        marker_en,
   output logic        de_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic [23:0] pixel_out,
   output logic        mark_valid
);

   // Arm half-length widened to the signed width of the difference terms.
   localparam logic signed [11:0] HALF_S = $signed({4'b0000, MARK_HALF});

   // Position counters and the centroid latch.
   logic [10:0] x_pos_q, x_pos_d;
   logic [10:0] y_pos_q, y_pos_d;
   logic        vsync_prev_q, vsync_prev_d;
   logic [10:0] xl_q, xl_d;
   logic [10:0] yl_q, yl_d;
   logic        mark_valid_q, mark_valid_d;

   // Stage 1: delayed video plus the registered hit decision.
   logic        s1_de_q, s1_de_d;
   logic        s1_hsync_q, s1_hsync_d;
   logic        s1_vsync_q, s1_vsync_d;
   logic [23:0] s1_pixel_q, s1_pixel_d;
   logic        s1_hit_q, s1_hit_d;

   // Stage 2: the output registers.
   logic        de_out_q, de_out_d;
   logic        hsync_out_q, hsync_out_d;
   logic        vsync_out_q, vsync_out_d;
   logic [23:0] pixel_out_q, pixel_out_d;

   // Hit-test intermediates.
   logic signed [11:0] dx, dy;
   logic               dx_ok, dy_ok, in_range;

   // Track the coordinates of the pixel currently presented on de_in.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path through
      // the if/else leaves it unassigned and no latch is inferred.
      x_pos_d = x_pos_q;
      y_pos_d = y_pos_q;
      if (vsync_in) begin
         x_pos_d = '0;
         y_pos_d = '0;
      end else if (de_in) begin
         if (x_pos_q == IMG_W - 11'd1) begin
            x_pos_d = '0;
            y_pos_d = (y_pos_q == IMG_H - 11'd1) ? 11'd0 : y_pos_q + 11'd1;
         end else begin
            x_pos_d = x_pos_q + 11'd1;
         end
      end
   end

   // Latch the centroid once per frame, when vsync_in falls, so the marker
   // cannot move partway through the active frame.
   always_comb begin
      vsync_prev_d = vsync_in;
      xl_d         = xl_q;
      yl_d         = yl_q;
      mark_valid_d = mark_valid_q;
      if (vsync_prev_q && !vsync_in) begin
         xl_d         = x_c;
         yl_d         = y_c;
         mark_valid_d = 1'b1;
      end
   end

   // Stage 1 hit test: the pixel lies on one of the two arms. Arms clip at the
   // image edges because the counters never leave the active area.
   always_comb begin
      dx         = $signed({1'b0, x_pos_q}) - $signed({1'b0, xl_q});
      dy         = $signed({1'b0, y_pos_q}) - $signed({1'b0, yl_q});
      dx_ok      = (dx >= -HALF_S) && (dx <= HALF_S);
      dy_ok      = (dy >= -HALF_S) && (dy <= HALF_S);
      in_range   = (xl_q < IMG_W) && (yl_q < IMG_H);
      s1_hit_d   = de_in && marker_en && mark_valid_q && in_range &&
                   (((dy == 12'sd0) && dx_ok) || ((dx == 12'sd0) && dy_ok));
      s1_de_d    = de_in;
      s1_hsync_d = hsync_in;
      s1_vsync_d = vsync_in;
      s1_pixel_d = pixel_in;
   end

   // Stage 2: substitute the marker colour on hit pixels. Everything else,
   // including blanking content, passes through unchanged.
   always_comb begin
      de_out_d    = s1_de_q;
      hsync_out_d = s1_hsync_q;
      vsync_out_d = s1_vsync_q;
      pixel_out_d = s1_hit_q ? MARK_RGB : s1_pixel_q;
   end

   // State register for all flops; everything clears on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_pos_q      <= '0;
         y_pos_q      <= '0;
         vsync_prev_q <= 1'b0;
         xl_q         <= '0;
         yl_q         <= '0;
         mark_valid_q <= 1'b0;
         s1_de_q      <= 1'b0;
         s1_hsync_q   <= 1'b0;
         s1_vsync_q   <= 1'b0;
         s1_pixel_q   <= '0;
         s1_hit_q     <= 1'b0;
         de_out_q     <= 1'b0;
         hsync_out_q  <= 1'b0;
         vsync_out_q  <= 1'b0;
         pixel_out_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments update all flops together at the
         // edge, so every pipeline stage reads the previous value of its
         // predecessor.
         x_pos_q      <= x_pos_d;
         y_pos_q      <= y_pos_d;
         vsync_prev_q <= vsync_prev_d;
         xl_q         <= xl_d;
         yl_q         <= yl_d;
         mark_valid_q <= mark_valid_d;
         s1_de_q      <= s1_de_d;
         s1_hsync_q   <= s1_hsync_d;
         s1_vsync_q   <= s1_vsync_d;
         s1_pixel_q   <= s1_pixel_d;
         s1_hit_q     <= s1_hit_d;
         de_out_q     <= de_out_d;
         hsync_out_q  <= hsync_out_d;
         vsync_out_q  <= vsync_out_d;
         pixel_out_q  <= pixel_out_d;
      end
   end

   assign de_out     = de_out_q;
   assign hsync_out  = hsync_out_q;
   assign vsync_out  = vsync_out_q;
   assign pixel_out  = pixel_out_q;
   assign mark_valid = mark_valid_q;

endmodule

// File: tb/tb_centroid_marker_overlay.sv
// Testbench for centroid_marker_overlay. It streams whole 64x64 frames with
// random pixels. The reference model works from the row and column the bench
// itself drives, plus the centroid it expects to be latched. The bench compares
// every output cycle two clocks later, counts the marked pixels in each frame,
// and checks mark_valid.
module tb_centroid_marker_overlay;

   localparam logic [23:0] MARK = 24'hFF0000;
   localparam int          W    = 64;
   localparam int          H    = 64;
   localparam int          HALF = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        de_in, hsync_in, vsync_in, marker_en;
   logic [23:0] pixel_in;
   logic [10:0] x_c, y_c;
   logic        de_out, hsync_out, vsync_out, mark_valid;
   logic [23:0] pixel_out;

   centroid_marker_overlay dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .de_in      (de_in),
      .hsync_in   (hsync_in),
      .vsync_in   (vsync_in),
      .pixel_in   (pixel_in),
      .x_c        (x_c),
      .y_c        (y_c),
      .marker_en  (marker_en),
      .de_out     (de_out),
      .hsync_out  (hsync_out),
      .vsync_out  (vsync_out),
      .pixel_out  (pixel_out),
      .mark_valid (mark_valid)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   int          mark_cnt;     // marked pixels seen at the output in this frame
   int          model_cnt;    // marked pixels the model predicts for this frame
   bit          mv_m;         // model: a centroid has been latched
   int          lx, ly;       // model: the latched centroid
   logic [26:0] exp_q[$];     // expected {de,hs,vs,pixel}, two cycles ahead

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int absi(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Cross-hair rule, written directly from the coordinates the bench drives.
   function automatic bit on_marker(input int r, input int c);
      if (!mv_m || lx >= W || ly >= H || r < 0 || c < 0) return 1'b0;
      return ((r == ly) && (absi(c - lx) <= HALF)) ||
             ((c == lx) && (absi(r - ly) <= HALF));
   endfunction

   function automatic logic [23:0] rand_pix();
      logic [23:0] p;
      p = 24'($urandom);
      if (p[23:16] == 8'hFF) p[23:16] = 8'h00;  // keep random data distinct from the marker
      return p;
   endfunction

   // One clock of stimulus. Compares the output belonging to the previous step.
   task automatic step(input logic de, input logic hs, input logic vs,
                       input logic [23:0] pix, input int r, input int c);
      logic        hit;
      logic [26:0] e;
      @(negedge clk);
      de_in    = de;
      hsync_in = hs;
      vsync_in = vs;
      pixel_in = pix;
      hit = de && marker_en && on_marker(r, c);
      if (hit) model_cnt++;
      exp_q.push_back({de, hs, vs, hit ? MARK : pix});
      @(posedge clk);
      #1;
      if (exp_q.size() == 2) begin
         e = exp_q.pop_front();
         check("stream", {5'b0, de_out, hsync_out, vsync_out, pixel_out}, {5'b0, e});
         if (de_out && pixel_out == MARK) mark_cnt++;
      end
   endtask

   // vsync blanking; the centroid is captured as vsync falls.
   task automatic vblank();
      repeat (3) step(1'b0, 1'b0, 1'b1, rand_pix(), -1, -1);
      mv_m = 1'b1;
      lx   = int'(x_c);
      ly   = int'(y_c);
      repeat (2) step(1'b0, 1'b0, 1'b0, rand_pix(), -1, -1);
   endtask

   // One active frame. gray: constant 808080 pixels. en_row: marker_en=1 from
   // this row onward. rand_en: marker_en random per pixel. xchg_row: x_c is
   // changed there. rst_row: reset is pulsed there. exp_cnt<0 means use the
   // model's count.
   task automatic frame(input bit gray, input int en_row, input bit rand_en,
                        input int xchg_row, input int rst_row, input int exp_cnt,
                        input string tag);
      mark_cnt  = 0;
      model_cnt = 0;
      for (int r = 0; r < H; r++) begin
         if (r == xchg_row) x_c = 11'd10;
         if (r == rst_row) begin
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("rst_outputs", {5'b0, de_out, hsync_out, vsync_out, pixel_out}, 32'd0);
            check("rst_mark_valid", {31'b0, mark_valid}, 32'd0);
            exp_q.delete();
            mv_m = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
         end
         for (int c = 0; c < W; c++) begin
            marker_en = rand_en ? 1'($urandom_range(0, 1)) : (r >= en_row);
            step(1'b1, 1'b0, 1'b0, gray ? 24'h808080 : rand_pix(), r, c);
         end
         for (int h = 0; h < 4; h++)
            step(1'b0, (h == 1 || h == 2), 1'b0, rand_pix(), -1, -1);
      end
      check({tag, "_marks"}, mark_cnt, (exp_cnt >= 0) ? exp_cnt : model_cnt);
      check({tag, "_mark_valid"}, {31'b0, mark_valid}, {31'b0, mv_m});
   endtask

   initial begin
      rst_n     = 1'b0;
      de_in     = 1'b0;
      hsync_in  = 1'b0;
      vsync_in  = 1'b0;
      pixel_in  = 24'h0;
      marker_en = 1'b1;
      x_c       = 11'd20;
      y_c       = 11'd30;
      mv_m      = 1'b0;
      lx        = 0;
      ly        = 0;
      #12;
      check("reset_outputs", {5'b0, de_out, hsync_out, vsync_out, pixel_out}, 32'd0);
      check("reset_mark_valid", {31'b0, mark_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Frame 1: no centroid latched yet, so the stream is a pure delay.
      frame(1'b0, 0, 1'b0, -1, -1, 0, "f1_no_latch");
      // Frame 2: gray input, cross at (20,30).
      vblank();
      frame(1'b1, 0, 1'b0, -1, -1, 33, "f2_gray");
      // Frame 3: corner clipping at (2,0).
      x_c = 11'd2;
      y_c = 11'd0;
      vblank();
      frame(1'b0, 0, 1'b0, -1, -1, 19, "f3_clip");
      // Frame 4: out-of-range centroid draws nothing.
      x_c = 11'd70;
      y_c = 11'd5;
      vblank();
      frame(1'b0, 0, 1'b0, -1, -1, 0, "f4_range");
      // Frame 5: x_c changes mid-frame and is ignored.
      x_c = 11'd40;
      y_c = 11'd50;
      vblank();
      frame(1'b0, 0, 1'b0, 32, -1, 33, "f5_hold");
      // Frame 6: marker_en low for rows 0..29.
      x_c = 11'd20;
      y_c = 11'd30;
      vblank();
      frame(1'b0, 30, 1'b0, -1, -1, 25, "f6_enable");
      // Frame 7: reset pulse at row 25.
      vblank();
      frame(1'b0, 0, 1'b0, -1, 25, 3, "f7_reset");
      // Frame 8: marker back after the next vsync; bottom-right corner.
      x_c = 11'd63;
      y_c = 11'd63;
      vblank();
      frame(1'b0, 0, 1'b0, -1, -1, 17, "f8_corner");
      // Frames 9-10: random centroid with a random per-pixel marker_en.
      for (int k = 0; k < 2; k++) begin
         x_c = 11'($urandom_range(0, 79));
         y_c = 11'($urandom_range(0, 79));
         vblank();
         frame(1'b0, 0, 1'b1, -1, -1, -1, "frand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
